// File: rtl/reg_stack_seq.sv
// reg_stack_seq: multi-register save/restore sequencer (STM/LDM style).
// It drives the register file's single read/write port and a word-addressed
// memory port. Push stores the masked registers to a descending stack. Pop
// loads the masked registers back from that stack.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   start, op, mask, base    request from the control unit (op: 0 = push, 1 = pop)
//   busy, done, sp_out, err  status; sp_out holds the final stack pointer
//   rf_rd, rf_latch          regfile index and write strobe
//   rf_wdata, rf_rdata       regfile write data and read data
//   mem_req, mem_we          memory request and direction
//   mem_addr, mem_wdata      memory address and write data
//   mem_rdata, mem_ack       memory read data and one-cycle acknowledge
//
// Optional feature (macro REGSTK_TIMEOUT_EN): a MEM cycle counter aborts the
// operation after TIMEOUT cycles without ack and sets the sticky err flag.
// When the macro is undefined, MEM waits indefinitely and err is tied to 0.
module reg_stack_seq #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned NREGS   = 8,
   parameter int unsigned RIDX_W  = 3,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op,
   input  logic [NREGS-1:0]  mask,
   input  logic [WIDTH-1:0]  base,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  sp_out,
   output logic              err,
   output logic [RIDX_W-1:0] rf_rd,
   output logic              rf_latch,
   output logic [WIDTH-1:0]  rf_wdata,
   input  logic [WIDTH-1:0]  rf_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [WIDTH-1:0]  mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SCAN = 3'd1,
      S_MEM  = 3'd2,
      S_WB   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic               op_q;
   logic [NREGS-1:0]   mask_q;
   logic [WIDTH-1:0]   ptr_q;
   logic [RIDX_W-1:0]  sel_idx;
   logic               sel_found;
   logic [NREGS-1:0]   sel_bit;
   logic               timeout_c;

   // Register selection: push takes the highest set bit, pop takes the lowest.
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (mask_q[i] && !(op_q && sel_found)) begin
            sel_idx   = RIDX_W'(i);
            sel_found = 1'b1;
         end
      end
   end

   assign sel_bit = NREGS'(1) << sel_idx;

`ifdef REGSTK_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CNT_W-1:0] cnt;
   logic             err_q;

   // The counter is held at zero outside MEM, so each MEM visit starts fresh.
   assign timeout_c = (state == S_MEM) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         if (state != S_MEM) cnt <= '0;
         else if (!mem_ack)  cnt <= cnt + CNT_W'(1);
         if (state == S_IDLE && start) err_q <= 1'b0;
         else if (timeout_c)           err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign timeout_c = 1'b0;
   assign err       = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_SCAN;
         S_SCAN: state_nxt = (mask_q == '0) ? S_DONE : S_MEM;
         S_MEM: begin
            if (timeout_c)    state_nxt = S_DONE;
            else if (mem_ack) state_nxt = op_q ? S_WB : S_SCAN;
         end
         S_WB:   state_nxt = S_SCAN;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode. mem_wdata passes regfile read data straight through.
   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      mem_req   = (state == S_MEM);
      mem_we    = (state == S_MEM) && !op_q;
      mem_wdata = ((state == S_MEM) && !op_q) ? rf_rdata : '0;
      rf_latch  = (state == S_WB);
   end

   // Datapath: latched request, stack pointer, regfile index and address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= 1'b0;
         mask_q   <= '0;
         ptr_q    <= '0;
         rf_rd    <= '0;
         rf_wdata <= '0;
         mem_addr <= '0;
         sp_out   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q   <= op;
                  mask_q <= mask;
                  ptr_q  <= base;
               end
            end
            S_SCAN: begin
               if (mask_q == '0) begin
                  sp_out <= ptr_q;
               end else begin
                  rf_rd  <= sel_idx;
                  mask_q <= mask_q & ~sel_bit;
                  // Push pre-decrements; pop addresses the current pointer.
                  if (!op_q) begin
                     ptr_q    <= ptr_q - WIDTH'(1);
                     mem_addr <= ptr_q - WIDTH'(1);
                  end else begin
                     mem_addr <= ptr_q;
                  end
               end
            end
            S_MEM: begin
               if (timeout_c)            sp_out   <= ptr_q;
               else if (mem_ack && op_q) rf_wdata <= mem_rdata;
            end
            S_WB: ptr_q <= ptr_q + WIDTH'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_stack_seq.sv
// Bench for reg_stack_seq. It models a register file and a memory with
// programmable ack delay. Expected results come from a stack model that
// places each register by its rank within the mask.
module tb_reg_stack_seq;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned NREGS  = 8;
   localparam int unsigned RIDX_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, op;
   logic [NREGS-1:0]  mask;
   logic [WIDTH-1:0]  base;
   logic              busy, done, err;
   logic [WIDTH-1:0]  sp_out;
   logic [RIDX_W-1:0] rf_rd;
   logic              rf_latch;
   logic [WIDTH-1:0]  rf_wdata, rf_rdata;
   logic              mem_req, mem_we;
   logic [WIDTH-1:0]  mem_addr, mem_wdata, mem_rdata;
   logic              mem_ack;

   reg_stack_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .RIDX_W(RIDX_W), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .mask(mask), .base(base),
      .busy(busy), .done(done), .sp_out(sp_out), .err(err),
      .rf_rd(rf_rd), .rf_latch(rf_latch), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   // Environment state.
   logic [15:0] regs [8];
   logic [15:0] mem_arr [logic [15:0]];
   logic [15:0] wr_addr_q [$];
   logic [15:0] wr_data_q [$];
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          latch_cnt = 0;
   int          req_cyc = 0;
   int          unstable = 0;
   int          busy_gap = 0;
   logic [15:0] p_addr, p_wdata;
   logic        p_we;
   int          n_pass = 0;
   int          n_total = 0;

   assign rf_rdata = regs[rf_rd];

   function automatic logic [15:0] rd_mem(input logic [15:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : (a ^ 16'h5A5A);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Regfile write port and memory responder, both acting on the negedge.
   always @(negedge clk) begin
      if (rf_latch) begin
         regs[rf_rd] = rf_wdata;
         latch_cnt++;
      end
      if (mem_req) begin
         req_cyc++;
         if (wait_cnt > 0 && (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we))
            unstable++;
         p_addr  = mem_addr;
         p_wdata = mem_wdata;
         p_we    = mem_we;
         wait_cnt++;
         if (wait_cnt > ack_delay) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem_arr[mem_addr] = mem_wdata;
               wr_addr_q.push_back(mem_addr);
               wr_data_q.push_back(mem_wdata);
            end else begin
               mem_rdata = rd_mem(mem_addr);
            end
         end else begin
            mem_ack = 1'b0;
         end
      end else begin
         wait_cnt = 0;
         mem_ack  = 1'b0;
      end
   end

   // Waits for done. At cycle 'poke' it pulses a conflicting start that must be ignored.
   task automatic wait_done(input int poke, output int cyc);
      cyc = 0;
      busy_gap = 0;
      for (int k = 1; k <= 3000; k++) begin
         @(negedge clk);
         if (k == poke) begin
            start = 1'b1; op = ~op; mask = 8'hFF; base = 16'h5555;
         end else begin
            start = 1'b0;
         end
         if (!busy) busy_gap++;
         if (done) begin
            cyc = k;
            break;
         end
      end
      if (cyc == 0) check("done_seen", 32'd0, 32'd1);
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      latch_cnt = 0;
      req_cyc   = 0;
      unstable  = 0;
   endtask

   task automatic issue(input logic o, input logic [7:0] m, input logic [15:0] b);
      @(negedge clk);
      op = o; mask = m; base = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; mask = '0; base = '0;
   endtask

   // Runs one operation and checks it against the stack model.
   task automatic do_op(input logic o, input logic [7:0] m, input logic [15:0] b,
                        input int d, input int poke,
                        output logic [15:0] sp, output int cyc);
      logic [15:0] exp_regs [8];
      logic [15:0] ea [$];
      logic [15:0] ed [$];
      logic [7:0]  below;
      logic [15:0] sp_e;
      int          n, cyc_e, rank;
      n = $countones(m);
      for (int i = 0; i < 8; i++) exp_regs[i] = regs[i];
      sp_e = o ? b + 16'(n) : b - 16'(n);
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) begin
            below = (8'h01 << i) - 8'h01;
            rank  = $countones(m & below);
            if (o) exp_regs[i] = rd_mem(b + 16'(rank));
            else begin
               ea.push_back(sp_e + 16'(rank));
               ed.push_back(regs[i]);
            end
         end
      end
      cyc_e = n * ((o ? 3 : 2) + d) + 2;
      ack_delay = d;
      clear_logs();
      issue(o, m, b);
      wait_done(poke, cyc);
      sp = sp_out;
      check("m_sp", 32'(sp_out), 32'(sp_e));
      check("m_cycles", 32'(cyc), 32'(cyc_e));
      check("m_err", 32'(err), 32'd0);
      check("m_busy_gap", 32'(busy_gap), 32'd0);
      check("m_latch", 32'(latch_cnt), o ? 32'(n) : 32'd0);
      check("m_req", 32'(req_cyc), 32'(n * (1 + d)));
      check("m_stable", 32'(unstable), 32'd0);
      check("m_wr_count", 32'(wr_addr_q.size()), 32'(ea.size()));
      for (int j = 0; j < ea.size() && j < wr_addr_q.size(); j++) begin
         check("m_wr_addr", 32'(wr_addr_q[j]), 32'(ea[j]));
         check("m_wr_data", 32'(wr_data_q[j]), 32'(ed[j]));
      end
      for (int i = 0; i < 8; i++) check("m_reg", 32'(regs[i]), 32'(exp_regs[i]));
      @(negedge clk);
      check("idle_after", 32'({busy, done}), 32'd0);
   endtask

   typedef struct {
      logic        op;
      logic [7:0]  mask;
      logic [15:0] base;
      int          delay;
      int          poke;
      logic [15:0] exp_sp;
      int          exp_cyc;
      int          exp_latch;
      int          exp_req;
   } vec_t;

   initial begin
      vec_t        vecs [8];
      logic [15:0] sp;
      int          cyc;

      vecs[0] = '{1'b0, 8'h05, 16'h0100, 0, 0, 16'h00FE,  6, 0,  2};
      vecs[1] = '{1'b1, 8'h05, 16'h00FE, 0, 0, 16'h0100,  8, 2,  2};
      vecs[2] = '{1'b0, 8'h00, 16'h1234, 0, 0, 16'h1234,  2, 0,  0};
      vecs[3] = '{1'b1, 8'h00, 16'hABCD, 0, 0, 16'hABCD,  2, 0,  0};
      vecs[4] = '{1'b0, 8'h80, 16'h0000, 5, 3, 16'hFFFF,  9, 0,  6};
      vecs[5] = '{1'b1, 8'hFF, 16'hFFFC, 0, 0, 16'h0004, 26, 8,  8};
      vecs[6] = '{1'b0, 8'hFF, 16'h0003, 1, 0, 16'hFFFB, 26, 0, 16};
      vecs[7] = '{1'b1, 8'h81, 16'h0010, 2, 0, 16'h0012, 12, 2,  6};

      for (int i = 0; i < 8; i++) regs[i] = 16'h0A00 + 16'(i);
      regs[0] = 16'h1111;
      regs[2] = 16'h2222;
      rst = 1'b1; start = 1'b0; op = 1'b0; mask = '0; base = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_latch", 32'(rf_latch), 32'd0);
      check("rst_sp", 32'(sp_out), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         if (i == 1) begin
            mem_arr[16'h00FE] = 16'hAAAA;
            mem_arr[16'h00FF] = 16'hBBBB;
         end
         do_op(vecs[i].op, vecs[i].mask, vecs[i].base, vecs[i].delay, vecs[i].poke, sp, cyc);
         check("t_sp", 32'(sp), 32'(vecs[i].exp_sp));
         check("t_cycles", 32'(cyc), 32'(vecs[i].exp_cyc));
         check("t_latch", 32'(latch_cnt), 32'(vecs[i].exp_latch));
         check("t_req", 32'(req_cyc), 32'(vecs[i].exp_req));
         if (i == 0) begin
            check("push_wr_n", 32'(wr_addr_q.size()), 32'd2);
            if (wr_addr_q.size() == 2) begin
               check("push_a0", 32'(wr_addr_q[0]), 32'h00FF);
               check("push_d0", 32'(wr_data_q[0]), 32'h2222);
               check("push_a1", 32'(wr_addr_q[1]), 32'h00FE);
               check("push_d1", 32'(wr_data_q[1]), 32'h1111);
            end
         end
         if (i == 1) begin
            check("pop_r0", 32'(regs[0]), 32'hAAAA);
            check("pop_r2", 32'(regs[2]), 32'hBBBB);
            check("pop_r1", 32'(regs[1]), 32'h0A01);
         end
      end

      // Reset asserted during a pop's MEM state.
      regs[2] = 16'h3C3C;
      ack_delay = 1000;
      clear_logs();
      issue(1'b1, 8'h04, 16'h0050);
      for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
      check("rst_mid_req_seen", 32'(mem_req), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      check("rst_mid_req", 32'(mem_req), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_latch", 32'(rf_latch), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_reg", 32'(regs[2]), 32'h3C3C);
      check("rst_mid_wr", 32'(latch_cnt), 32'd0);
      do_op(1'b1, 8'h04, 16'h0050, 0, 0, sp, cyc);
      check("post_rst_sp", 32'(sp), 32'h0051);

`ifdef REGSTK_TIMEOUT_EN
      // No ack: abort after four request cycles with err set.
      ack_delay = 1000;
      clear_logs();
      issue(1'b0, 8'h03, 16'h0010);
      wait_done(0, cyc);
      check("to_cycles", 32'(cyc), 32'd6);
      check("to_err", 32'(err), 32'd1);
      check("to_sp", 32'(sp_out), 32'h000F);
      check("to_req", 32'(req_cyc), 32'd4);
      @(negedge clk);
      check("to_err_sticky", 32'(err), 32'd1);
      ack_delay = 0;
      issue(1'b0, 8'h00, 16'h0000);
      check("to_err_clear", 32'(err), 32'd0);
      wait_done(0, cyc);
      @(negedge clk);
`endif

      // Randomized operations against the model.
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 8; i++) if ($urandom_range(0, 1) == 1) regs[i] = 16'($urandom);
         do_op(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
               int'($urandom_range(0, 2)), 0, sp, cyc);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_stack_seq.md
Name: reg_stack_seq

Overview:
Multi-register save/restore sequencer that drives the register file's single read/write port (rd, r_latch, busD_in/busD_out) and a word-addressed memory port. It runs push (store a register mask to a descending stack) and pop (load a register mask from it), like STM/LDM. It sits between the control unit, which issues start/op/mask/base, and the memory bus.

Parameters:
WIDTH, 16, data and address width
NREGS, 8, number of registers (width of mask)
RIDX_W, 3, register index width (log2 NREGS)
TIMEOUT, 255, memory-ack timeout in cycles (used only with REGSTK_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; accepted only in IDLE
op  in  1  0 = push, 1 = pop; sampled with start
mask  in  NREGS  registers to transfer; sampled with start
base  in  WIDTH  initial stack pointer; sampled with start
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
sp_out  out  WIDTH  final stack pointer; valid with done, held until the next start
err  out  1  timeout flag (constant 0 without the macro)
rf_rd  out  RIDX_W  register index to the regfile rd input
rf_latch  out  1  regfile write strobe (r_latch)
rf_wdata  out  WIDTH  write data to the regfile (busD_in)
rf_rdata  in  WIDTH  read data from the regfile (busD_out = regs[rf_rd])
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  WIDTH  word address
mem_wdata  out  WIDTH  write data
mem_rdata  in  WIDTH  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion, sampled on posedge

Behaviour:
- Reset (async, any state): all outputs 0; state IDLE; internal mask, pointer and op cleared. Reset mid-operation drops mem_req immediately, and no further regfile write occurs.
- Flow: IDLE -> SCAN -> {MEM -> (push: SCAN | pop: WB -> SCAN)}* -> DONE -> IDLE.
- IDLE: on posedge with start=1, latch op, mask, ptr=base, clear err, go to SCAN. busy is high from the next cycle through the DONE cycle inclusive.
- start while busy is ignored.
- SCAN:
  - If the remaining mask is 0, go to DONE.
  - Push: select the highest set bit. Pop: select the lowest set bit.
  - Register the index on rf_rd and clear that bit.
  - Push only: ptr = ptr - 1 (pre-decrement).
  - mem_addr = ptr (new value for push, current value for pop).
  - Go to MEM.
- MEM:
  - mem_req=1, mem_we=~op.
  - Push: mem_wdata = rf_rdata, passed through combinationally.
  - Hold mem_addr, mem_we and mem_wdata stable until mem_ack is seen high on a posedge.
  - On ack, push: deassert mem_req, go to SCAN.
  - On ack, pop: capture mem_rdata into rf_wdata, go to WB.
- WB (pop only): rf_latch=1 for exactly this cycle, rf_rd and rf_wdata stable; the regfile writes on the mid-cycle negedge. Leaving WB: ptr = ptr + 1 (post-increment), go to SCAN.
- DONE: done=1 for one cycle; sp_out = ptr, held afterwards; go to IDLE, busy=0.
- mem_ack outside MEM is ignored.
- Pointer arithmetic is modulo 2^WIDTH (0x0000 - 1 = 0xFFFF, wrap silently).
- Latency with zero-wait ack:
  - Push: 2 cycles per register.
  - Pop: 3 cycles per register.
  - Plus SCAN-empty 1 and DONE 1.
  - Empty mask: done asserts 2 cycles after the start edge, sp_out = base.
- Stack layout: lowest register index at lowest address, so push then pop with the same mask restores the registers and the pointer.
- rf_latch is never asserted during push.

Optional Feature:
REGSTK_TIMEOUT_EN
- Defined:
  - A counter is cleared on entering MEM and increments each MEM cycle without ack.
  - On reaching TIMEOUT: drop mem_req, set err=1, skip the remaining mask, go to DONE.
  - sp_out = ptr at abort. For push, that ptr includes the decrement already made for the aborted transfer.
  - err is sticky until the next accepted start.
- Undefined: no counter; MEM waits indefinitely; err tied 0.

Test Plan:
- Push: r0=0x1111, r2=0x2222, mask=0x05, base=0x0100, ack same cycle as req -> writes (0x00FF, 0x2222) then (0x00FE, 0x1111); done with sp_out=0x00FE; rf_latch never high.
- Pop: memory[0x00FE]=0xAAAA, memory[0x00FF]=0xBBBB, mask=0x05, base=0x00FE -> r0=0xAAAA, r2=0xBBBB; one rf_latch pulse each; sp_out=0x0100; other registers unchanged.
- mask=0x00, base=0x1234 -> no mem_req; done exactly 2 cycles after the start edge; sp_out=0x1234.
- Push mask=0x80, base=0x0000, ack delayed 5 cycles -> mem_addr=0xFFFF and mem_wdata held for 6 req cycles; sp_out=0xFFFF; a start pulsed mid-operation is ignored.
- rst asserted during a pop's MEM state -> mem_req, busy and rf_latch drop immediately, asynchronously; target register not written; next start runs normally.
- With REGSTK_TIMEOUT_EN and TIMEOUT=4, push mask=0x03, base=0x10, no ack -> req high 4 cycles, err=1, done pulse, sp_out=0x000F; next start clears err.
